// File: rtl/prime_ctrl_pkg.sv
// Shared constants for the prime detector: controller state encoding and default operand width.
package prime_ctrl_pkg;

    localparam int unsigned NBITS_DEFAULT = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/prime_ctrl.sv
// Trial-division primality controller; drives an external divider and tests d = 2, 3, ...
// until a factor is found or the quotient drops to d or below.
//
// state | meaning
// IDLE  | ready for a candidate; small candidates (<4) are decided at once
// ISSUE | presenting n_reg / d to the divider
// WAIT  | waiting for the quotient
// CHECK | divisibility and termination test on q, d
// DONE  | presenting the verdict
module prime_ctrl
    import prime_ctrl_pkg::*;
#(
    parameter int unsigned nbits = NBITS_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [nbits-1:0] n,
    input  logic             istream_val,
    output logic             istream_rdy,
    output logic             is_prime,
    output logic             ostream_val,
    input  logic             ostream_rdy,
    output logic [nbits-1:0] div_opa,
    output logic [nbits-1:0] div_opb,
    output logic             div_istream_val,
    input  logic             div_istream_rdy,
    input  logic [nbits-1:0] div_result,
    input  logic             div_ostream_val,
    output logic             div_ostream_rdy
);

    localparam logic [nbits-1:0] SMALL_LIM = nbits'(4);
    localparam logic [nbits-1:0] D_FIRST   = nbits'(2);
    localparam logic [nbits-1:0] D_STEP    = nbits'(1);

    state_e             state_q, state_d;
    logic [nbits-1:0]   n_reg_q, n_reg_d;
    logic [nbits-1:0]   dv_q, dv_d;
    logic [nbits-1:0]   quo_q, quo_d;
    logic               verdict_q, verdict_d;
    logic [2*nbits-1:0] prod;
    logic               divisible;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            n_reg_q   <= '0;
            dv_q      <= D_FIRST;
            quo_q     <= '0;
            verdict_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_reg_q   <= n_reg_d;
            dv_q      <= dv_d;
            quo_q     <= quo_d;
            verdict_q <= verdict_d;
        end
    end

    assign prod      = {{nbits{1'b0}}, quo_q} * {{nbits{1'b0}}, dv_q};
    assign divisible = (prod == {{nbits{1'b0}}, n_reg_q});

    always_comb begin
        state_d   = state_q;
        n_reg_d   = n_reg_q;
        dv_d      = dv_q;
        quo_d     = quo_q;
        verdict_d = verdict_q;
        case (state_q)
            ST_IDLE: begin
                if (istream_val) begin
                    n_reg_d = n;
                    dv_d    = D_FIRST;
                    if (n < SMALL_LIM) begin
                        // 2 and 3 are the only primes below 4, both with bit 1 set
                        verdict_d = n[1];
                        state_d   = ST_DONE;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (div_istream_rdy) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (div_ostream_val) begin
                    quo_d   = div_result;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (divisible) begin
                    verdict_d = 1'b0;
                    state_d   = ST_DONE;
                end else if (quo_q <= dv_q) begin
                    // q <= d means d has passed sqrt(n) with no factor found
                    verdict_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    dv_d    = dv_q + D_STEP;
                    state_d = ST_ISSUE;
                end
            end
            ST_DONE: begin
                if (ostream_rdy) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        istream_rdy     = reset && (state_q == ST_IDLE);
        ostream_val     = (state_q == ST_DONE);
        is_prime        = (state_q == ST_DONE) && verdict_q;
        div_istream_val = (state_q == ST_ISSUE);
        div_opa         = (state_q == ST_ISSUE) ? n_reg_q : '0;
        div_opb         = (state_q == ST_ISSUE) ? dv_q : '0;
        div_ostream_rdy = (state_q == ST_WAIT);
    end

endmodule

// File: doc/prime_ctrl.md
PRIME_CTRL -- requirements
Module: prime_ctrl

Interface
REQ-001 The block SHALL take parameter nbits, default 16, giving the candidate and divider operand width.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-004 The block SHALL have port n, input, nbits, the candidate number.
REQ-005 The block SHALL have ports istream_val (input, 1) and istream_rdy (output, 1), the request handshake for n.
REQ-006 The block SHALL have port is_prime, output, 1 bit, the verdict (1 = prime).
REQ-007 The block SHALL have ports ostream_val (output, 1) and ostream_rdy (input, 1), the response handshake for is_prime.
REQ-008 The block SHALL have ports div_opa (output, nbits), div_opb (output, nbits), div_istream_val (output, 1) and div_istream_rdy (input, 1), the divider request channel.
REQ-009 The block SHALL have ports div_result (input, nbits), div_ostream_val (input, 1) and div_ostream_rdy (output, 1), the divider quotient channel.

Function
REQ-010 A transfer SHALL occur on any channel only in a cycle where val and rdy are both high at the rising clk edge.
REQ-011 The block SHALL implement states IDLE, ISSUE, WAIT, CHECK and DONE.
REQ-012 IDLE: istream_rdy=1; on transfer, latch n into n_reg and load d=2; go to DONE if n_reg<4, otherwise go to ISSUE.
REQ-013 For n<4 the verdict SHALL be 1 for n=2 or 3 and 0 for n=0 or 1, with no divider request issued.
REQ-014 ISSUE: div_istream_val=1, div_opa=n_reg, div_opb=d; on transfer go to WAIT; operands SHALL stay stable while val is high and rdy is low.
REQ-015 WAIT: div_ostream_rdy=1; on transfer, latch q=div_result and go to CHECK.
REQ-016 div_ostream_rdy SHALL be 0 in every state other than WAIT.
REQ-017 CHECK, divisible (q*d==n_reg, compared at 2*nbits width): verdict SHALL be 0 and the next state DONE.
REQ-018 CHECK, not divisible and q<=d: verdict SHALL be 1 and the next state DONE.
REQ-019 CHECK, otherwise: d SHALL increment by 1 and the next state SHALL be ISSUE.
REQ-020 d SHALL never exceed floor(sqrt(2^nbits-1))+1, so d SHALL never wrap.
REQ-021 DONE: ostream_val=1 and is_prime holds the verdict; on transfer go to IDLE.
REQ-022 is_prime SHALL be stable while ostream_val=1 and ostream_rdy=0.
REQ-023 istream_rdy SHALL be 0 outside IDLE, so exactly one candidate is in flight.
REQ-024 Latency, excluding backpressure, SHALL be 2 cycles (IDLE to DONE) for n<4.
REQ-025 For n>=4, each trial SHALL cost 1 ISSUE cycle, plus the divider latency, plus 1 CHECK cycle.
REQ-026 A new request SHALL be acceptable in the cycle after the response transfer.

Reset
REQ-027 While reset=0, state SHALL be IDLE, d=2, n_reg=0, q=0 and verdict=0, regardless of clk.
REQ-028 While reset=0, outputs SHALL be istream_rdy=0, ostream_val=0, is_prime=0, div_istream_val=0, div_ostream_rdy=0 and div_opa=div_opb=0.
REQ-029 The first cycle after reset deasserts SHALL be IDLE with istream_rdy=1.
REQ-030 Reset mid-operation SHALL abandon the candidate with no response issued.
REQ-031 The divider SHALL share the same reset, so no stale quotient is consumed after reset.

Structure
REQ-032 State encodings (IDLE=0 to DONE=4, 3 bits) and the 16-bit default width SHALL live in a shared constants include used by the controller and the top-level prime detector.
REQ-033 The divider SHALL stay external, connected at the level above; prime_ctrl SHALL instantiate no sub-module.
REQ-034 The only arithmetic SHALL be the nbits x nbits multiply-compare and the d incrementer.

Verification
REQ-035 Bench: n=0, 1, 2, 3 -> is_prime 0, 0, 1, 1, each 2 cycles after accept, with zero divider requests.
REQ-036 Bench: n=91 -> is_prime=0 after trials d=2..7 (6 divider requests); n=25 -> 0 at d=5.
REQ-037 Bench: n=97 -> is_prime=1 after d=2..10 (9 requests); n=65521 -> is_prime=1 with the final trial at d=256, where q<=d.
REQ-038 Bench: random ostream_rdy and div_istream_rdy stalls on n=97 -> same verdict, with operands and is_prime held stable during stalls.
REQ-039 Bench: assert reset=0 during WAIT of n=91 -> all outputs at reset values immediately; then n=7 -> is_prime=1.
REQ-040 Bench: back-to-back stream n=4, 5, 6, 7 with ostream_rdy=1 -> 0, 1, 0, 1 in order, istream_rdy low while busy.
